// File: rtl/usbdev_aon_wake_ctrl.sv
// usbdev_aon_wake_ctrl
//
// AON-domain handshake controller wrapped around the USB wake detector.
// One-cycle suspend / wake-ack requests from the IP become level requests
// to the detector. While the detector is active the controller collects the
// wake cause, raises a level wakeup to the power manager, counts
// detector-initiated wakes and flags handshakes the detector fails to follow.
//
// Ports:
//   clk_aon_i, rst_aon_i    AON clock, synchronous active-high reset
//   suspend_pulse_i         one-cycle request to hand control to AON
//   wake_ack_pulse_i        one-cycle request to return control to the IP
//   err_clr_i, cnt_clr_i    one-cycle clears of err_o / wake_cnt_o
//   wake_detect_active_i    detector active-state feedback
//   wake_req_aon_i          detector wake request
//   bus_not_idle_aon_i, bus_reset_aon_i, sense_lost_aon_i  detector events
//   suspend_req_aon_o       level suspend request (state Arming)
//   wake_ack_aon_o          level wake ack (state Releasing)
//   wakeup_o                level wakeup request (state WakePending)
//   wake_cause_o            sticky {sense_lost, bus_reset, bus_not_idle}
//   wake_cnt_o              saturating count of detector-initiated wakes
//   err_o                   sticky handshake error
//   state_o                 FSM state for debug

module usbdev_aon_wake_ctrl #(
    parameter int HandshakeTimeout = 8,
    parameter int CntW             = 8
) (
    input  logic            clk_aon_i,
    input  logic            rst_aon_i,
    input  logic            suspend_pulse_i,
    input  logic            wake_ack_pulse_i,
    input  logic            err_clr_i,
    input  logic            cnt_clr_i,
    input  logic            wake_detect_active_i,
    input  logic            wake_req_aon_i,
    input  logic            bus_not_idle_aon_i,
    input  logic            bus_reset_aon_i,
    input  logic            sense_lost_aon_i,
    output logic            suspend_req_aon_o,
    output logic            wake_ack_aon_o,
    output logic            wakeup_o,
    output logic [2:0]      wake_cause_o,
    output logic [CntW-1:0] wake_cnt_o,
    output logic            err_o,
    output logic [2:0]      state_o
);

    typedef enum logic [2:0] {
        Idle        = 3'd0,
        Arming      = 3'd1,
        Monitor     = 3'd2,
        WakePending = 3'd3,
        Releasing   = 3'd4
    } state_e;

    localparam logic [7:0] TimeoutLast = 8'(HandshakeTimeout - 1);

    state_e     state, state_next;
    logic [7:0] timer;
    logic       timeout;
    logic       err_set;
    logic       cnt_inc;
    logic       cause_clr;
    logic       cause_acc;

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (&v) ? v : v + CntW'(1);
    endfunction

    always_comb begin
        state_next = state;
        err_set    = 1'b0;
        cnt_inc    = 1'b0;
        cause_clr  = 1'b0;
        cause_acc  = 1'b0;
        timeout    = (timer == TimeoutLast);
        case (state)
            Idle: begin
                if (suspend_pulse_i) begin
                    state_next = Arming;
                    cause_clr  = 1'b1;
                end
            end
            Arming: begin
                // Software abort wins over both the detector and the timer.
                if (wake_ack_pulse_i) begin
                    state_next = Releasing;
                end else if (wake_detect_active_i) begin
                    state_next = Monitor;
                end else if (timeout) begin
                    state_next = Idle;
                    err_set    = 1'b1;
                end
            end
            Monitor: begin
                cause_acc = 1'b1;
                // A detector wake is counted even when software acks in the
                // same cycle; the ack then skips the wakeup phase.
                if (wake_req_aon_i) begin
                    cnt_inc    = 1'b1;
                    state_next = wake_ack_pulse_i ? Releasing : WakePending;
                end else if (wake_ack_pulse_i) begin
                    state_next = Releasing;
                end else if (!wake_detect_active_i) begin
                    state_next = Idle;
                    err_set    = 1'b1;
                end
            end
            WakePending: begin
                cause_acc = 1'b1;
                if (wake_ack_pulse_i) begin
                    state_next = Releasing;
                end
            end
            Releasing: begin
                if (!wake_detect_active_i) begin
                    state_next = Idle;
                end else if (timeout) begin
                    state_next = Idle;
                    err_set    = 1'b1;
                end
            end
            default: state_next = Idle;
        endcase
    end

    always_ff @(posedge clk_aon_i) begin
        if (rst_aon_i) begin
            state             <= Idle;
            timer             <= 8'd0;
            wake_cause_o      <= 3'b000;
            wake_cnt_o        <= '0;
            err_o             <= 1'b0;
            suspend_req_aon_o <= 1'b0;
            wake_ack_aon_o    <= 1'b0;
            wakeup_o          <= 1'b0;
        end else begin
            state <= state_next;

            if (state_next != state) begin
                timer <= 8'd0;
            end else if (state == Arming || state == Releasing) begin
                timer <= timer + 8'd1;
            end

            if (cause_clr) begin
                wake_cause_o <= 3'b000;
            end else if (cause_acc) begin
                wake_cause_o <= wake_cause_o |
                    {sense_lost_aon_i, bus_reset_aon_i, bus_not_idle_aon_i};
            end

            if (cnt_clr_i) begin
                wake_cnt_o <= '0;
            end else if (cnt_inc) begin
                wake_cnt_o <= sat_inc(wake_cnt_o);
            end

            // A new error outranks a coincident clear.
            if (err_set) begin
                err_o <= 1'b1;
            end else if (err_clr_i) begin
                err_o <= 1'b0;
            end

            // Level outputs follow the state being entered, so they line up
            // with the registered state one cycle after the request pulse.
            suspend_req_aon_o <= (state_next == Arming);
            wake_ack_aon_o    <= (state_next == Releasing);
            wakeup_o          <= (state_next == WakePending);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_usbdev_aon_wake_ctrl.sv
// Directed testbench for usbdev_aon_wake_ctrl. A default instance (CntW=8)
// and a narrow-counter instance (CntW=2) share all stimulus.

module tb_usbdev_aon_wake_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       suspend, ack_pulse, err_clr, cnt_clr;
    logic       active, wake_req, bni, brst, sl;
    logic       suspend_req, wake_ack, wakeup, err;
    logic [2:0] cause, state;
    logic [7:0] cnt;
    logic       suspend_req2, wake_ack2, wakeup2, err2;
    logic [2:0] cause2, state2;
    logic [1:0] cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    usbdev_aon_wake_ctrl #(.HandshakeTimeout(8), .CntW(8)) dut (
        .clk_aon_i(clk), .rst_aon_i(rst),
        .suspend_pulse_i(suspend), .wake_ack_pulse_i(ack_pulse),
        .err_clr_i(err_clr), .cnt_clr_i(cnt_clr),
        .wake_detect_active_i(active), .wake_req_aon_i(wake_req),
        .bus_not_idle_aon_i(bni), .bus_reset_aon_i(brst), .sense_lost_aon_i(sl),
        .suspend_req_aon_o(suspend_req), .wake_ack_aon_o(wake_ack),
        .wakeup_o(wakeup), .wake_cause_o(cause), .wake_cnt_o(cnt),
        .err_o(err), .state_o(state)
    );

    usbdev_aon_wake_ctrl #(.HandshakeTimeout(8), .CntW(2)) dut_c2 (
        .clk_aon_i(clk), .rst_aon_i(rst),
        .suspend_pulse_i(suspend), .wake_ack_pulse_i(ack_pulse),
        .err_clr_i(err_clr), .cnt_clr_i(cnt_clr),
        .wake_detect_active_i(active), .wake_req_aon_i(wake_req),
        .bus_not_idle_aon_i(bni), .bus_reset_aon_i(brst), .sense_lost_aon_i(sl),
        .suspend_req_aon_o(suspend_req2), .wake_ack_aon_o(wake_ack2),
        .wakeup_o(wakeup2), .wake_cause_o(cause2), .wake_cnt_o(cnt2),
        .err_o(err2), .state_o(state2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full suspend / bus wake / ack / release cycle, stimulus only.
    task automatic do_wake(input logic clr);
        suspend = 1'b1; tick(); suspend = 1'b0;
        active = 1'b1; tick();
        wake_req = 1'b1; bni = 1'b1; cnt_clr = clr; tick();
        wake_req = 1'b0; bni = 1'b0; cnt_clr = 1'b0;
        ack_pulse = 1'b1; tick(); ack_pulse = 1'b0;
        active = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        suspend = 0; ack_pulse = 0; err_clr = 0; cnt_clr = 0;
        active = 0; wake_req = 0; bni = 0; brst = 0; sl = 0;
        tick(); tick();
        checks++;
        if ({state, suspend_req, wake_ack, wakeup, cause, cnt, err} !== 18'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {state, suspend_req, wake_ack, wakeup, cause, cnt, err});
        end
        checks++;
        if ({state2, cnt2, err2} !== 6'd0) begin
            failures++;
            $display("FAIL reset_outputs_c2 got=%b exp=0", {state2, cnt2, err2});
        end
        rst = 1'b0;
    endtask

    task automatic test_suspend_handshake();
        suspend = 1'b1; tick(); suspend = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if ({state, suspend_req} !== {3'd1, 1'b1}) begin
                failures++;
                $display("FAIL arming_req cycle=%0d got=%b exp=%b", c, {state, suspend_req}, {3'd1, 1'b1});
            end
            if (c == 3) active = 1'b1;
            tick();
        end
        checks++;
        if ({state, suspend_req, err} !== {3'd2, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL enter_monitor got=%b exp=%b", {state, suspend_req, err}, {3'd2, 2'b00});
        end
    endtask

    task automatic test_bus_wake();
        wake_req = 1'b1; brst = 1'b1; tick(); brst = 1'b0;
        checks++;
        if ({state, wakeup, cause, cnt} !== {3'd3, 1'b1, 3'b010, 8'd1}) begin
            failures++;
            $display("FAIL bus_wake got=%b exp=%b", {state, wakeup, cause, cnt}, {3'd3, 1'b1, 3'b010, 8'd1});
        end
        tick();
        wake_req = 1'b0;
        checks++;
        if ({state, cnt} !== {3'd3, 8'd1}) begin
            failures++;
            $display("FAIL wake_single_count got=%b exp=%b", {state, cnt}, {3'd3, 8'd1});
        end
        ack_pulse = 1'b1; tick(); ack_pulse = 1'b0;
        checks++;
        if ({state, wake_ack, wakeup} !== {3'd4, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL release got=%b exp=%b", {state, wake_ack, wakeup}, {3'd4, 2'b10});
        end
        tick();
        checks++;
        if ({state, wake_ack} !== {3'd4, 1'b1}) begin
            failures++;
            $display("FAIL release_hold got=%b exp=%b", {state, wake_ack}, {3'd4, 1'b1});
        end
        active = 1'b0; tick();
        checks++;
        if ({state, suspend_req, wake_ack, wakeup, err, cause} !== {3'd0, 4'b0000, 3'b010}) begin
            failures++;
            $display("FAIL back_to_idle got=%b exp=%b",
                     {state, suspend_req, wake_ack, wakeup, err, cause}, {3'd0, 4'b0000, 3'b010});
        end
    endtask

    task automatic test_ignored_requests();
        ack_pulse = 1'b1; tick(); ack_pulse = 1'b0;
        checks++;
        if ({state, wake_ack} !== {3'd0, 1'b0}) begin
            failures++;
            $display("FAIL ack_in_idle got=%b exp=%b", {state, wake_ack}, {3'd0, 1'b0});
        end
    endtask

    task automatic test_arming_timeout();
        suspend = 1'b1; tick(); suspend = 1'b0;
        checks++;
        if (cause !== 3'b000) begin
            failures++;
            $display("FAIL cause_clear_on_suspend got=%b exp=000", cause);
        end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if ({state, err} !== {3'd1, 1'b0}) begin
                failures++;
                $display("FAIL arming_wait k=%0d got=%b exp=%b", k, {state, err}, {3'd1, 1'b0});
            end
            tick();
        end
        checks++;
        if ({state, err, suspend_req} !== {3'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL arming_timeout got=%b exp=%b", {state, err, suspend_req}, {3'd0, 2'b10});
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_clr got=%b exp=0", err);
        end
    endtask

    task automatic test_err_priority();
        suspend = 1'b1; tick(); suspend = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++;
        if ({state, err} !== {3'd0, 1'b1}) begin
            failures++;
            $display("FAIL err_set_beats_clr got=%b exp=%b", {state, err}, {3'd0, 1'b1});
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
    endtask

    task automatic test_abort_release_timeout();
        suspend = 1'b1; tick(); suspend = 1'b0;
        active = 1'b1; ack_pulse = 1'b1; tick(); ack_pulse = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if ({state, wake_ack, suspend_req, err} !== {3'd4, 3'b100}) begin
                failures++;
                $display("FAIL abort_release k=%0d got=%b exp=%b", k, {state, wake_ack, suspend_req, err}, {3'd4, 3'b100});
            end
            tick();
        end
        checks++;
        if ({state, wake_ack, err} !== {3'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL release_timeout got=%b exp=%b", {state, wake_ack, err}, {3'd0, 2'b01});
        end
        active = 1'b0; err_clr = 1'b1; tick(); err_clr = 1'b0;
    endtask

    task automatic test_monitor_drop();
        suspend = 1'b1; tick(); suspend = 1'b0;
        active = 1'b1; tick();
        suspend = 1'b1; tick(); suspend = 1'b0;
        checks++;
        if ({state, err} !== {3'd2, 1'b0}) begin
            failures++;
            $display("FAIL suspend_in_monitor got=%b exp=%b", {state, err}, {3'd2, 1'b0});
        end
        active = 1'b0; tick();
        checks++;
        if ({state, err} !== {3'd0, 1'b1}) begin
            failures++;
            $display("FAIL monitor_drop got=%b exp=%b", {state, err}, {3'd0, 1'b1});
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
    endtask

    task automatic test_simultaneous();
        suspend = 1'b1; tick(); suspend = 1'b0;
        active = 1'b1; tick();
        wake_req = 1'b1; ack_pulse = 1'b1; bni = 1'b1; tick();
        wake_req = 1'b0; ack_pulse = 1'b0; bni = 1'b0;
        checks++;
        if ({state, wakeup, wake_ack, cnt, cause} !== {3'd4, 1'b0, 1'b1, 8'd2, 3'b001}) begin
            failures++;
            $display("FAIL simultaneous got=%b exp=%b", {state, wakeup, wake_ack, cnt, cause},
                     {3'd4, 1'b0, 1'b1, 8'd2, 3'b001});
        end
        active = 1'b0; tick();
        checks++;
        if ({state, wakeup} !== {3'd0, 1'b0}) begin
            failures++;
            $display("FAIL simultaneous_idle got=%b exp=%b", {state, wakeup}, {3'd0, 1'b0});
        end
    endtask

    task automatic test_saturation();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        checks++;
        if ({cnt, cnt2} !== 10'd0) begin
            failures++;
            $display("FAIL cnt_clr got=%0d/%0d exp=0/0", cnt, cnt2);
        end
        for (int i = 1; i <= 4; i++) begin
            do_wake(1'b0);
            checks++;
            if ({cnt2, cnt} !== {2'((i > 3) ? 3 : i), 8'(i)}) begin
                failures++;
                $display("FAIL cnt_sat wake=%0d got=%0d/%0d exp=%0d/%0d", i, cnt2, cnt, (i > 3) ? 3 : i, i);
            end
        end
        do_wake(1'b1);
        checks++;
        if ({cnt2, cnt} !== 10'd0) begin
            failures++;
            $display("FAIL cnt_clr_with_inc got=%0d/%0d exp=0/0", cnt2, cnt);
        end
    endtask

    task automatic test_reset_in_wakepending();
        suspend = 1'b1; tick(); suspend = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        suspend = 1'b1; tick(); suspend = 1'b0;
        active = 1'b1; tick();
        wake_req = 1'b1; sl = 1'b1; tick(); wake_req = 1'b0; sl = 1'b0;
        checks++;
        if ({state, wakeup, err, cause} !== {3'd3, 1'b1, 1'b1, 3'b100}) begin
            failures++;
            $display("FAIL pre_reset_state got=%b exp=%b", {state, wakeup, err, cause}, {3'd3, 2'b11, 3'b100});
        end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({state, wakeup, cause, err, cnt} !== 16'd0) begin
            failures++;
            $display("FAIL reset_in_wakepending got=%b exp=0", {state, wakeup, cause, err, cnt});
        end
        active = 1'b0;
    endtask

    initial begin
        test_reset();
        test_suspend_handshake();
        test_bus_wake();
        test_ignored_requests();
        test_arming_timeout();
        test_err_priority();
        test_abort_release_timeout();
        test_monitor_drop();
        test_simultaneous();
        test_saturation();
        test_reset_in_wakepending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/usbdev_aon_wake_ctrl.md
Name: usbdev_aon_wake_ctrl

Overview:
AON-domain handshake controller that sits directly upstream of usbdev_aon_wake and also consumes its outputs. It turns one-cycle suspend and wake-ack requests from the IP into the level suspend_req_aon / wake_ack_aon signals. It tracks the detector's active state, latches the wake cause, raises a level wakeup request to the power manager, counts wakes, and flags handshake timeouts.

Parameters:
HandshakeTimeout, 8, cycles allowed for the detector to follow a request (Arming or Releasing); legal range 2..255
CntW, 8, width of the wake event counter

Ports:
clk_aon_i  in  1  AON clock (~200 kHz)
rst_aon_i  in  1  synchronous, active-high reset
suspend_pulse_i  in  1  one-cycle request to hand control to AON, already synchronized to AON
wake_ack_pulse_i  in  1  one-cycle request to return control to the IP, already synchronized to AON
err_clr_i  in  1  one-cycle clear of err_o
cnt_clr_i  in  1  one-cycle clear of wake_cnt_o
wake_detect_active_i  in  1  active-state feedback from the wake detector
wake_req_aon_i  in  1  wake request from the detector
bus_not_idle_aon_i  in  1  event flag from the detector
bus_reset_aon_i  in  1  event flag from the detector
sense_lost_aon_i  in  1  event flag from the detector
suspend_req_aon_o  out  1  level suspend request to the detector
wake_ack_aon_o  out  1  level wake ack to the detector
wakeup_o  out  1  level wakeup request to the power manager
wake_cause_o  out  3  sticky cause: {sense_lost, bus_reset, bus_not_idle}
wake_cnt_o  out  CntW  saturating count of detector-initiated wakes
err_o  out  1  sticky handshake error
state_o  out  3  FSM state for debug

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs and state are registered.
- Reset values: state = Idle; every output = 0; timer = 0.
- State encoding: Idle=0, Arming=1, Monitor=2, WakePending=3, Releasing=4.
- Idle:
  - suspend_pulse_i -> Arming on the next edge; clear wake_cause_o and the timer.
  - wake_ack_pulse_i is ignored.
- Arming:
  - suspend_req_aon_o = 1.
  - wake_detect_active_i = 1 -> Monitor.
  - Otherwise, when the timer reaches HandshakeTimeout-1 -> set err_o and go to Idle.
  - wake_ack_pulse_i takes priority over both: abort -> Releasing.
- Monitor:
  - Each cycle, OR the event inputs into wake_cause_o.
  - wake_req_aon_i = 1 -> WakePending; increment wake_cnt_o once.
  - wake_ack_pulse_i (software-initiated wake) -> Releasing.
  - If wake_req_aon_i and wake_ack_pulse_i arrive in the same cycle: count the wake, latch the cause, go to Releasing. wakeup_o is not asserted.
  - wake_detect_active_i = 0 without a request -> set err_o and go to Idle.
- WakePending:
  - wakeup_o = 1 and the cause keeps OR-ing.
  - wake_ack_pulse_i -> Releasing.
  - No timeout in this state.
- Releasing:
  - wake_ack_aon_o = 1.
  - wake_detect_active_i = 0 -> Idle.
  - Timeout as in Arming -> set err_o and go to Idle.
- Outputs are decoded from the registered state, so a request appears one cycle after its pulse.
- Timer: CntW-independent 8-bit counter. Reset on every state change; increments only in Arming and Releasing.
- suspend_pulse_i outside Idle is ignored, with no error.
- wake_cnt_o saturates at all-ones.
- Clears:
  - cnt_clr_i clears wake_cnt_o. If it coincides with an increment, the result is 0.
  - err_clr_i clears err_o. If it coincides with a new error, err_o stays 1.
- Reset asserted in any state returns everything to reset values on the next edge.

Test Plan:
- Suspend handshake: suspend_pulse_i at cycle 0, wake_detect_active_i rises at cycle 3 -> suspend_req_aon_o = 1 in cycles 1..3; state_o = 2 at cycle 4; suspend_req_aon_o = 0 from cycle 4.
- Bus wake: in Monitor, raise wake_req_aon_i and bus_reset_aon_i -> state_o = 3, wakeup_o = 1, wake_cause_o = 3'b010, wake_cnt_o = 1. Then wake_ack_pulse_i -> wake_ack_aon_o = 1 until the detector drops active -> Idle with all handshake outputs 0.
- Arming timeout (HandshakeTimeout = 8), active never rises -> err_o = 1 and state_o = 0 exactly 8 cycles after entering Arming. err_clr_i -> err_o = 0.
- Simultaneous wake_req_aon_i and wake_ack_pulse_i in Monitor -> state_o = 4, wakeup_o stays 0, wake_cnt_o increments by 1.
- Counter saturation (CntW = 2): four bus wakes -> wake_cnt_o = 3. cnt_clr_i together with a fifth wake -> 0.
- Reset in WakePending -> next cycle state_o = 0, wakeup_o = 0, wake_cause_o = 0, err_o = 0.
